// File: rtl/address_range_decoder_programmable_pkg.sv
// Shared definitions for the programmable address range decoder:
// configuration field encodings, range register reset values and a
// ceil-log2 helper used to size the priority encoder.
package addr_range_decoder_pkg;

  // Field selected by a configuration write.
  typedef enum logic [1:0] {
    CFG_SEL_BASE     = 2'd0,
    CFG_SEL_BOUND    = 2'd1,
    CFG_SEL_ENABLE   = 2'd2,
    CFG_SEL_RESERVED = 2'd3
  } cfg_sel_e;

  // Reset values leave every range empty: base above bound, disabled.
  // Wide constants are sliced down to the configured address width.
  localparam int          RANGE_REG_MAX_WIDTH = 64;
  localparam logic [63:0] RANGE_BASE_RST      = {64{1'b1}};
  localparam logic [63:0] RANGE_BOUND_RST     = 64'd0;
  localparam logic        RANGE_ENABLE_RST    = 1'b0;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/address_range_decoder_programmable_if.sv
// Bus bundle for the programmable address range decoder: configuration
// write port, lookup request and lookup result. The master drives the
// configuration and requests; the slave (the decoder) drives results.
interface address_range_decoder_programmable_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RANGE_COUNT = 4,
  parameter int INDEX_WIDTH = 2
);

  logic                   cfg_wren;
  logic [INDEX_WIDTH-1:0] cfg_index;
  logic [1:0]             cfg_sel;
  logic [ADDR_WIDTH-1:0]  cfg_data;

  logic                   in_valid;
  logic [ADDR_WIDTH-1:0]  in_addr;

  logic                   out_valid;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic                   out_hit;
  logic [INDEX_WIDTH-1:0] out_index;
  logic [RANGE_COUNT-1:0] out_hit_vector;
  logic                   out_multi_hit;

  modport master (
    output cfg_wren, cfg_index, cfg_sel, cfg_data, in_valid, in_addr,
    input  out_valid, out_addr, out_hit, out_index, out_hit_vector, out_multi_hit
  );

  modport slave (
    input  cfg_wren, cfg_index, cfg_sel, cfg_data, in_valid, in_addr,
    output out_valid, out_addr, out_hit, out_index, out_hit_vector, out_multi_hit
  );

endinterface

// File: rtl/address_range_decoder_programmable_compare.sv
// Single-range comparator: an address matches when the range is enabled
// and base <= addr <= bound (unsigned, inclusive). A range programmed with
// base > bound can never satisfy both bounds and therefore never matches.
module address_range_compare #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] bound,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  match
);

  // Inclusive unsigned window test gated by the range enable.
  always_comb begin
    match = enable && (addr >= base) && (addr <= bound);
  end

endmodule

// File: rtl/address_range_decoder_programmable.sv
// Run-time programmable multi-range address decoder.
// Range registers are written through the configuration port; every
// lookup is compared against all ranges, the raw match vector is
// registered in stage 1, and stage 2 registers the vector, its OR, the
// lowest matching index and (optionally) a multiple-match flag.
// Optional feature macro: ADDR_RANGE_DECODER_MULTI_HIT_EN enables the
// registered out_multi_hit flag; without it out_multi_hit is tied to 0.
module address_range_decoder_programmable
  import addr_range_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RANGE_COUNT = 4,
  parameter int INDEX_WIDTH = 2
) (
  input logic clock,
  input logic reset_n,
  address_range_decoder_programmable_if.slave bus
);

  // Width that exactly covers the range indices; zero-extended to the
  // port width so a wider INDEX_WIDTH is harmless.
  localparam int ENC_WIDTH = (ceil_log2(RANGE_COUNT) < 1) ? 1 : ceil_log2(RANGE_COUNT);

  localparam logic [ADDR_WIDTH-1:0] BASE_RST  = RANGE_BASE_RST[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] BOUND_RST = RANGE_BOUND_RST[ADDR_WIDTH-1:0];

  logic [RANGE_COUNT-1:0] match_s;

  logic                   s1_valid_r;
  logic [ADDR_WIDTH-1:0]  s1_addr_r;
  logic [RANGE_COUNT-1:0] s1_vec_r;

  logic [ENC_WIDTH-1:0]   enc_s;

  logic                   out_valid_r;
  logic [ADDR_WIDTH-1:0]  out_addr_r;
  logic                   out_hit_r;
  logic [INDEX_WIDTH-1:0] out_index_r;
  logic [RANGE_COUNT-1:0] out_vec_r;

  // Per-range register set and comparator. A write only lands in the range
  // whose index equals cfg_index, so indices >= RANGE_COUNT select nothing.
  for (genvar i = 0; i < RANGE_COUNT; i++) begin : g_range
    logic                  wr_sel_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] bound_r;
    logic                  enable_r;

    assign wr_sel_s = bus.cfg_wren && (bus.cfg_index == INDEX_WIDTH'(i));

    // Update the selected field of this range; reserved field writes are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        base_r   <= BASE_RST;
        bound_r  <= BOUND_RST;
        enable_r <= RANGE_ENABLE_RST;
      end else if (wr_sel_s) begin
        case (cfg_sel_e'(bus.cfg_sel))
          CFG_SEL_BASE:     base_r   <= bus.cfg_data;
          CFG_SEL_BOUND:    bound_r  <= bus.cfg_data;
          CFG_SEL_ENABLE:   enable_r <= bus.cfg_data[0];
          CFG_SEL_RESERVED: enable_r <= enable_r;
          default:          enable_r <= enable_r;
        endcase
      end
    end

    address_range_compare #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_compare (
      .base   (base_r),
      .bound  (bound_r),
      .enable (enable_r),
      .addr   (bus.in_addr),
      .match  (match_s[i])
    );
  end

  // Stage 1: capture the request and the raw match vector. Comparison uses
  // range values from before any same-edge write. Data holds during bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      s1_vec_r   <= '0;
    end else begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_addr_r <= bus.in_addr;
        s1_vec_r  <= match_s;
      end
    end
  end

  // Priority encoder: scan from the top so the lowest set index is the last write.
  always_comb begin
    enc_s = '0;
    for (int i = RANGE_COUNT - 1; i >= 0; i--) begin
      if (s1_vec_r[i]) begin
        enc_s = ENC_WIDTH'(i);
      end else begin
        enc_s = enc_s;
      end
    end
  end

  // Stage 2: register the final result; data holds and only valid drops on a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= '0;
      out_hit_r   <= 1'b0;
      out_index_r <= '0;
      out_vec_r   <= '0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_addr_r  <= s1_addr_r;
        out_hit_r   <= |s1_vec_r;
        out_index_r <= INDEX_WIDTH'(enc_s);
        out_vec_r   <= s1_vec_r;
      end
    end
  end

`ifdef ADDR_RANGE_DECODER_MULTI_HIT_EN
  logic out_multi_r;

  // Two or more bits set: clearing the lowest set bit still leaves a one.
  function automatic logic at_least_two(input logic [RANGE_COUNT-1:0] vec);
    return (vec & (vec - RANGE_COUNT'(1'b1))) != '0;
  endfunction

  // Multiple-match flag registered alongside the other stage-2 fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_multi_r <= 1'b0;
    end else if (s1_valid_r) begin
      out_multi_r <= at_least_two(s1_vec_r);
    end
  end

  assign bus.out_multi_hit = out_multi_r;
`else
  assign bus.out_multi_hit = 1'b0;
`endif

  assign bus.out_valid      = out_valid_r;
  assign bus.out_addr       = out_addr_r;
  assign bus.out_hit        = out_hit_r;
  assign bus.out_index      = out_index_r;
  assign bus.out_hit_vector = out_vec_r;

endmodule

// File: doc/address_range_decoder_programmable.md
# address_range_decoder_programmable

Multi-range, run-time-programmable address decoder. Holds RANGE_COUNT base/bound/enable register sets written through a configuration port, and compares every lookup address against all ranges in a 2-stage pipeline. Returns a per-range hit vector, the lowest-indexed matching range, and a registered copy of the address. Sits between an address source (core, bus bridge) and the I/O or memory select logic, replacing fixed decoders where the memory map must change at run time.

## Interface
- ADDR_WIDTH, 32, lookup and range address width
- RANGE_COUNT, 4, number of programmable ranges (>= 1)
- INDEX_WIDTH, 2, width of range index; must be >= ceil(log2(RANGE_COUNT)), minimum 1

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_wren  in  1  configuration write strobe
- cfg_index  in  INDEX_WIDTH  range selected for write
- cfg_sel  in  2  field: 0 base, 1 bound, 2 enable (cfg_data[0]), 3 reserved
- cfg_data  in  ADDR_WIDTH  write data
- in_valid  in  1  lookup request
- in_addr  in  ADDR_WIDTH  lookup address
- out_valid  out  1  result valid
- out_addr  out  ADDR_WIDTH  address of this result
- out_hit  out  1  at least one enabled range matched
- out_index  out  INDEX_WIDTH  lowest matching range index; 0 on miss
- out_hit_vector  out  RANGE_COUNT  per-range match, bit i = range i
- out_multi_hit  out  1  more than one range matched (see Configuration)

## Operation
- Range i matches when enable[i]=1 and base[i] <= addr <= bound[i]. Comparison is unsigned and inclusive at both ends.
- A range with base > bound never matches.
- Reset values: base = all ones, bound = 0, enable = 0. After reset every range is empty.
- Config write: on a clock edge with cfg_wren=1, the field named by cfg_sel of range cfg_index is updated.
  - cfg_sel=3 writes are ignored.
  - Writes with cfg_index >= RANGE_COUNT are ignored.
  - Enable writes use cfg_data[0] only.
- Stage 1 registers valid, addr and the raw per-range match vector.
- Stage 2 registers:
  - the vector, copied to out_hit_vector;
  - out_hit, the OR-reduction of the vector;
  - out_index, from a priority encoder where the lowest index wins;
  - out_multi_hit;
  - out_addr and out_valid.
- No backpressure: a lookup is accepted every cycle. When in_valid=0, a bubble propagates. The data fields of a bubble hold their last values, and only out_valid is forced to 0.
- Overlapping ranges are legal. Priority resolves them and out_hit_vector shows every match.

## Timing
- Lookup latency is 2 cycles: in_valid at edge N produces out_valid at edge N+2. Throughput is 1 lookup per cycle.
- Every output resets to 0.
- A config write and a lookup on the same edge: the lookup compares against the pre-write values. The write is visible to lookups sampled from the next edge onward.
- A config write never disturbs results already in flight in stage 1 or 2.
- reset_n asserted mid-stream clears the pipeline valids and all range registers immediately. In-flight lookups are lost and out_valid=0 until new input arrives after deassertion.
- Deassertion of reset_n is synchronised by the integrating level.

## Configuration
- ADDR_RANGE_DECODER_MULTI_HIT_EN
  - Defined: out_multi_hit is a registered flag, set when 2 or more bits of the stage-1 vector are 1, aligned with out_valid.
  - Undefined: the popcount logic is omitted and out_multi_hit is tied to 0.

## Structure
- Package addr_range_decoder_pkg holds:
  - cfg_sel encodings (CFG_SEL_BASE=0, CFG_SEL_BOUND=1, CFG_SEL_ENABLE=2);
  - range register reset constants;
  - the ceil-log2 helper function.
- Sub-module address_range_compare: purely combinational; takes base, bound, enable and addr, and outputs match. Instantiated RANGE_COUNT times in a generate loop.
- Config registers, both pipeline stages and the priority encoder live in the top module.

## Test plan
- Reset then lookup 0x0000_0000 and 0xFFFF_FFFF -> out_hit=0, out_hit_vector=0, out_valid 2 cycles after each in_valid.
- Range 1 = [0x1000,0x1FFF] enabled; lookups 0x0FFF, 0x1000, 0x1FFF, 0x2000 -> hit 0,1,1,0; out_index=1 on hits.
- Range 0 = [0x1800,0x27FF], range 2 = [0x1000,0x1FFF], both enabled; lookup 0x1900 -> out_index=0, vector=0b0101, out_multi_hit=1 with the macro defined, 0 without it.
- Same-edge write of range 3 enable=1 (base 0x0, bound 0xFF) with lookup 0x10 -> that lookup misses; lookup 0x10 on the next cycle -> hit, index 3.
- Back-to-back lookups with one bubble, then reset_n pulsed while 2 lookups are in flight -> output order preserved, bubble gives out_valid=0, reset drops out_valid immediately and clears all ranges.
- Write with cfg_sel=3 and cfg_index=5 (RANGE_COUNT=4, INDEX_WIDTH=3) -> no range changes; subsequent lookups unchanged.
